// File: rtl/dport_pkg.sv
// Shared encodings and address map constants for the dport register front end.
package dport_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SLV  = 1'b1
  } state_t;

  localparam logic [19:0] STS_BASE    = 20'h00100;
  localparam logic [31:0] TIMEOUT_PAT = 32'hDEADBEEF;
  localparam int          REG_HI      = 23;
  localparam int          REG_LO      = 20;

endpackage

// File: rtl/regs_strb_reg.sv
// One 32-bit control word with per-byte write enables.
// Updates on the edge where we is high; async reset loads RST.
module regs_strb_reg #(
  parameter logic [31:0] RST = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST;
    end else if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb[k]) q[k*8 +: 8] <= wdata[k*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/regs_bridge.sv
// ARM register request decoder: local ctl/sts bank, NSLV req/ack channels, slave timeout.
// Local and decode errors ack one cycle after the start; slave accesses ack one cycle after slvack.
module regs_bridge
  import dport_pkg::*;
#(
  parameter int NCTL    = 4,
  parameter int NSTS    = 2,
  parameter int NSLV    = 2,
  parameter int SLVAW   = 20,
  parameter int TIMEOUT = 1024,
  parameter logic [NCTL*32-1:0] CTL_RST = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           armaddr,
  input  logic [31:0]           armwdata,
  input  logic [3:0]            armwstrb,
  input  logic                  armwr,
  input  logic                  armreq,
  output logic [31:0]           armrdata,
  output logic                  armack,
  output logic                  armerr,
  output logic [NSLV*SLVAW-1:0] slvaddr,
  output logic [NSLV*32-1:0]    slvwdata,
  output logic [NSLV*4-1:0]     slvwstrb,
  output logic [NSLV-1:0]       slvwr,
  output logic [NSLV-1:0]       slvreq,
  input  logic [NSLV-1:0]       slvack,
  input  logic [NSLV-1:0]       slverr,
  input  logic [NSLV*32-1:0]    slvrdata,
  output logic [NCTL*32-1:0]    ctl,
  input  logic [NSTS*32-1:0]    sts
);

  state_t      state, state_nxt;
  logic        armreq0;
  logic [3:0]  cur;
  logic [31:0] cnt;

  logic [3:0]  region;
  logic [19:0] off;
  logic [31:0] ctl_idx, sts_idx;
  logic        start, ctl_hit, sts_hit, is_local, is_slv, local_ok, timeout;
  logic [31:0] local_rdata, sel_rdata;
  logic        sel_ack, sel_err;
  logic [NCTL-1:0] ctl_we;
  logic        unused_addr;

  assign unused_addr = ^armaddr[31:24];

  always_comb begin
    region      = armaddr[REG_HI:REG_LO];
    off         = armaddr[19:0] & ~20'h3;
    start       = armreq & ~armreq0 & (state == IDLE);
    ctl_idx     = {14'd0, off[19:2]};
    sts_idx     = {14'd0, off[19:2]} - {14'd0, STS_BASE[19:2]};
    ctl_hit     = ctl_idx < 32'(NCTL);
    sts_hit     = (off >= STS_BASE) && (sts_idx < 32'(NSTS));
    is_local    = (region == 4'd0);
    is_slv      = !is_local && ({28'd0, region} <= 32'(NSLV));
    // Status words are read-only, so a write only lands on a ctl hit.
    local_ok    = armwr ? ctl_hit : (ctl_hit || sts_hit);
    local_rdata = '0;
    ctl_we      = '0;
    for (int i = 0; i < NCTL; i++) begin
      if (ctl_idx == 32'(i)) begin
        if (ctl_hit && !armwr) local_rdata = ctl[i*32 +: 32];
        ctl_we[i] = start & is_local & armwr;
      end
    end
    for (int j = 0; j < NSTS; j++) begin
      if (sts_hit && !armwr && !ctl_hit && sts_idx == 32'(j)) local_rdata = sts[j*32 +: 32];
    end
    sel_ack   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int c = 0; c < NSLV; c++) begin
      if (cur == 4'(c)) begin
        sel_ack   = slvack[c];
        sel_err   = slverr[c];
        sel_rdata = slvrdata[c*32 +: 32];
      end
    end
    timeout = (cnt == 32'(TIMEOUT - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && is_slv) state_nxt = SLV;
      SLV:     if (sel_ack || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armreq0  <= 1'b0;
      armack   <= 1'b0;
      armerr   <= 1'b0;
      armrdata <= '0;
      cur      <= '0;
      cnt      <= '0;
      slvaddr  <= '0;
      slvwdata <= '0;
      slvwstrb <= '0;
      slvwr    <= '0;
      slvreq   <= '0;
    end else begin
      armreq0 <= armreq;
      armack  <= 1'b0;
      if (start) begin
        if (is_slv) begin
          cur <= 4'(region - 4'd1);
          cnt <= '0;
          for (int c = 0; c < NSLV; c++) begin
            if (region == 4'(c + 1)) begin
              slvaddr[c*SLVAW +: SLVAW] <= armaddr[SLVAW-1:0];
              slvwdata[c*32 +: 32]      <= armwdata;
              slvwstrb[c*4 +: 4]        <= armwstrb;
              slvwr[c]                  <= armwr;
              slvreq[c]                 <= 1'b1;
            end
          end
        end else begin
          armack   <= 1'b1;
          armerr   <= !(is_local && local_ok);
          armrdata <= (is_local && local_ok) ? local_rdata : 32'h0;
        end
      end else if (state == SLV) begin
        if (sel_ack || timeout) begin
          // Ack wins over a timeout landing on the same edge.
          armack   <= 1'b1;
          armerr   <= sel_ack ? sel_err : 1'b1;
          armrdata <= sel_ack ? sel_rdata : TIMEOUT_PAT;
          for (int c = 0; c < NSLV; c++) begin
            if (cur == 4'(c)) slvreq[c] <= 1'b0;
          end
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < NCTL; i++) begin : g_ctl
    regs_strb_reg #(
      .RST(CTL_RST[i*32 +: 32])
    ) u_reg (
      .clk   (clk),
      .rst   (rst),
      .we    (ctl_we[i]),
      .wstrb (armwstrb),
      .wdata (armwdata),
      .q     (ctl[i*32 +: 32])
    );
  end

endmodule

// File: tb/tb_regs_bridge.sv
// Randomized bench for regs_bridge against an address-map level reference model.
module tb_regs_bridge;
  localparam int NCTL = 4, NSTS = 2, NSLV = 2, SLVAW = 20, TIMEOUT = 16;
  localparam logic [NCTL*32-1:0] CTL_RST = {32'h0BADF00D, 32'h0, 32'h0, 32'h0};

  logic clk = 1'b0;
  logic rst;
  logic [31:0] armaddr, armwdata, armrdata;
  logic [3:0]  armwstrb;
  logic armwr, armreq, armack, armerr;
  logic [NSLV*SLVAW-1:0] slvaddr;
  logic [NSLV*32-1:0]    slvwdata, slvrdata;
  logic [NSLV*4-1:0]     slvwstrb;
  logic [NSLV-1:0]       slvwr, slvreq, slvack, slverr;
  logic [NCTL*32-1:0]    ctl;
  logic [NSTS*32-1:0]    sts;

  int checks = 0, errors = 0;
  logic [31:0] ctl_m [NCTL];
  logic [31:0] sts_m [NSTS];

  always #5 clk = ~clk;

  regs_bridge #(
    .NCTL(NCTL), .NSTS(NSTS), .NSLV(NSLV), .SLVAW(SLVAW), .TIMEOUT(TIMEOUT), .CTL_RST(CTL_RST)
  ) dut (
    .clk(clk), .rst(rst), .armaddr(armaddr), .armwdata(armwdata), .armwstrb(armwstrb),
    .armwr(armwr), .armreq(armreq), .armrdata(armrdata), .armack(armack), .armerr(armerr),
    .slvaddr(slvaddr), .slvwdata(slvwdata), .slvwstrb(slvwstrb), .slvwr(slvwr),
    .slvreq(slvreq), .slvack(slvack), .slverr(slverr), .slvrdata(slvrdata),
    .ctl(ctl), .sts(sts)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_sts(input int j, input logic [31:0] v);
    sts_m[j] = v;
    sts[j*32 +: 32] = v;
  endtask

  task automatic check_ctl();
    for (int i = 0; i < NCTL; i++) check("ctl_word", ctl[i*32 +: 32], ctl_m[i]);
  endtask

  // delay: SLV edge on which slvack is presented (0 = never); late: ack once after completion.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input bit wr, input int delay, input logic [31:0] srd, input bit serr,
                     input bit late);
    int r, c, k, hi, lat, idx;
    logic [19:0] off;
    logic [31:0] exp_rd;
    logic [NSLV-1:0] onehot;
    bit exp_err;
    r   = int'(addr[23:20]);
    off = addr[19:0] & 20'hFFFFC;
    @(negedge clk);
    armaddr = addr; armwdata = wdata; armwstrb = wstrb; armwr = wr; armreq = 1'b1;
    if (r >= 1 && r <= NSLV) begin
      c = r - 1;
      onehot = '0;
      onehot[c] = 1'b1;
      @(posedge clk); #1;
      check("slvreq_set", slvreq, onehot);
      check("slvaddr", slvaddr[c*SLVAW +: SLVAW], addr[SLVAW-1:0]);
      check("slvwdata", slvwdata[c*32 +: 32], wdata);
      check("slvwstrb", slvwstrb[c*4 +: 4], wstrb);
      check("slvwr", slvwr[c], wr);
      k = 0; hi = 1;
      while (!armack && k < TIMEOUT + 4) begin
        @(negedge clk);
        slvack = NSLV'($urandom);
        slvack[c] = 1'b0;
        slverr = NSLV'($urandom);
        for (int q = 0; q < NSLV; q++) slvrdata[q*32 +: 32] = $urandom;
        if (k + 1 == delay) begin
          slvack[c] = 1'b1; slverr[c] = serr; slvrdata[c*32 +: 32] = srd;
        end
        @(posedge clk); #1;
        k++;
        if (slvreq[c]) hi++;
      end
      lat     = (delay >= 1 && delay <= TIMEOUT) ? delay : TIMEOUT;
      exp_err = (delay >= 1 && delay <= TIMEOUT) ? serr : 1'b1;
      exp_rd  = (delay >= 1 && delay <= TIMEOUT) ? srd : 32'hDEADBEEF;
      check("slv_latency", 64'(k), 64'(lat));
      check("slvreq_cycles", 64'(hi), 64'(lat));
      check("slv_armack", armack, 1'b1);
      check("slv_armerr", armerr, exp_err);
      check("slv_armrdata", armrdata, exp_rd);
      check("slvreq_drop", slvreq, '0);
      @(negedge clk);
      slvack = '0;
      if (late) begin
        slvack[c] = 1'b1; slverr[c] = 1'b0;
      end
      armreq = 1'b0;
      @(posedge clk); #1;
      check("armack_pulse", armack, 1'b0);
      check("slvreq_idle", slvreq, '0);
      @(negedge clk);
      slvack = '0;
    end else begin
      exp_err = 1'b1; exp_rd = 32'h0;
      if (r == 0) begin
        if (off < 20'(4*NCTL)) begin
          idx = int'(off) / 4;
          exp_err = 1'b0;
          if (wr) begin
            for (int b = 0; b < 4; b++) if (wstrb[b]) ctl_m[idx][b*8 +: 8] = wdata[b*8 +: 8];
          end else begin
            exp_rd = ctl_m[idx];
          end
        end else if (!wr && off >= 20'h100 && off < 20'(256 + 4*NSTS)) begin
          exp_err = 1'b0;
          exp_rd = sts_m[(int'(off) - 256) / 4];
        end
      end
      @(posedge clk); #1;
      check("loc_armack", armack, 1'b1);
      check("loc_armerr", armerr, exp_err);
      if (!wr || exp_err) check("loc_armrdata", armrdata, exp_rd);
      check("loc_noslvreq", slvreq, '0);
      @(negedge clk);
      armreq = 1'b0;
      @(posedge clk); #1;
      check("armack_pulse", armack, 1'b0);
    end
    check_ctl();
  endtask

  initial begin
    int kind;
    logic [31:0] a;
    rst = 1'b1; armaddr = '0; armwdata = '0; armwstrb = '0; armwr = 1'b0; armreq = 1'b0;
    slvack = '0; slverr = '0; slvrdata = '0; sts = '0;
    for (int i = 0; i < NCTL; i++) ctl_m[i] = CTL_RST[i*32 +: 32];
    for (int j = 0; j < NSTS; j++) set_sts(j, $urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_armack", armack, 1'b0);
    check("rst_armerr", armerr, 1'b0);
    check("rst_armrdata", armrdata, 32'h0);
    check("rst_slvreq", slvreq, '0);
    check("rst_slvaddr", slvaddr, '0);
    check("rst_ctl3", ctl[127:96], 32'h0BADF00D);
    check_ctl();
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    txn(32'h000004, 32'h12345678, 4'b0101, 1'b1, 0, 0, 1'b0, 1'b0);
    check("ctl1_strobe", ctl[63:32], 32'h00340078);
    set_sts(0, 32'hCAFEF00D);
    txn(32'h000100, 0, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0);
    check("sts0_read", armrdata, 32'hCAFEF00D);
    txn(32'h000200, 0, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0);
    txn(32'h200010, 0, 4'hF, 1'b0, 3, 32'hA5, 1'b0, 1'b0);
    txn(32'h100020, 32'h55AA55AA, 4'hF, 1'b1, 0, 0, 1'b0, 1'b1);
    txn(32'h100024, 32'h1, 4'h3, 1'b1, TIMEOUT, 32'h77, 1'b1, 1'b0);
    txn(32'hF00000, 0, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0);
    txn(32'h00010C, 0, 4'hF, 1'b1, 0, 0, 1'b0, 1'b0);

    // Reset while a slave access is pending
    @(negedge clk);
    armaddr = 32'h100040; armwr = 1'b0; armreq = 1'b1;
    @(posedge clk); #1;
    check("rstmid_slvreq_set", slvreq[0], 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; armreq = 1'b0;
    #1;
    check("rstmid_slvreq", slvreq, '0);
    check("rstmid_armack", armack, 1'b0);
    for (int i = 0; i < NCTL; i++) ctl_m[i] = CTL_RST[i*32 +: 32];
    check_ctl();
    @(posedge clk); #1;
    check("rstmid_noack", armack, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      for (int j = 0; j < NSTS; j++) set_sts(j, $urandom);
      kind = $urandom_range(0, 5);
      a = $urandom;
      case (kind)
        0: a[23:0] = 24'(4 * $urandom_range(0, NCTL - 1));
        1: a[23:0] = 24'(4 * $urandom_range(0, NCTL - 1) + $urandom_range(0, 3));
        2: a[23:0] = 24'(256 + 4 * $urandom_range(0, NSTS - 1));
        3: a[23:20] = 4'd0;
        4: a[23:20] = 4'($urandom_range(1, NSLV));
        default: a[23:20] = 4'($urandom_range(NSLV + 1, 15));
      endcase
      txn(a, $urandom, 4'($urandom), (kind == 0) ? 1'b1 : (kind == 1 || kind == 2) ? 1'b0 : 1'($urandom),
          $urandom_range(0, TIMEOUT + 3), $urandom, 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_bridge.md
Name: regs_bridge

Overview:
- Parametrised successor of the DisplayPort control-register front end.
- Decodes ARM-side register requests into:
  - a local bank of NCTL read/write control words,
  - NSTS read-only status words,
  - NSLV generic downstream req/ack channels (AUX, debug, future PHY/link blocks).
- New over the previous generation: byte-strobed local writes, error ack for unmapped addresses, and a per-transaction slave timeout.
- Sits between the ARM bus adapter and all dport sub-blocks.

Parameters:
- NCTL, 4: number of 32-bit control registers, 1..64.
- NSTS, 2: number of 32-bit status inputs, 1..64.
- NSLV, 2: number of downstream channels, 1..15.
- SLVAW, 20: downstream address width, at most 20.
- TIMEOUT, 1024: cycles to wait for slvack before erroring, at least 2.
- CTL_RST, 0: reset value of ctl, NCTL*32 bits, flattened.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- armaddr  in  32  byte address
- armwdata  in  32  write data
- armwstrb  in  4  byte strobes
- armwr  in  1  1=write
- armreq  in  1  request level; transaction starts on its rising edge
- armrdata  out  32  read data, valid with armack
- armack  out  1  one-cycle completion pulse
- armerr  out  1  error flag, valid with armack
- slvaddr  out  NSLV*SLVAW  per-channel address
- slvwdata  out  NSLV*32  per-channel write data
- slvwstrb  out  NSLV*4  per-channel strobes
- slvwr  out  NSLV  per-channel write flag
- slvreq  out  NSLV  per-channel request level
- slvack  in  NSLV  per-channel acknowledge
- slverr  in  NSLV  per-channel error, sampled with slvack
- slvrdata  in  NSLV*32  per-channel read data, sampled with slvack
- ctl  out  NCTL*32  control registers
- sts  in  NSTS*32  status words

Behaviour:
Reset (async, immediate):
- armack=0, armerr=0, armrdata=0.
- All slvreq=0; slvaddr/slvwdata/slvwstrb/slvwr=0.
- ctl=CTL_RST; state=IDLE; timeout counter=0; armreq0=0.

Start and decode:
- armreq0 registers armreq every cycle.
- A start is armreq & !armreq0 while in IDLE. Starts in any other state are dropped; masters must wait for armack.
- Decode uses armaddr[23:20]=R; offset is armaddr[19:0] & ~3.

R=0, local bank (state stays IDLE):
- armack=1 the cycle after the start.
- Write, offset 4i with i<NCTL: byte k of ctl[i] updates only when armwstrb[k]=1; armerr=0.
- Read, offset 4i with i<NCTL: armrdata=ctl[i]; armerr=0.
- Read, offset 0x100+4j with j<NSTS: armrdata=sts[j]; armerr=0.
- Any other local access, including writes to status: armack=1, armerr=1, armrdata=0, no state change.

1<=R<=NSLV, downstream channel c=R-1:
- Load channel c's slvaddr=armaddr[SLVAW-1:0], slvwdata, slvwstrb, slvwr.
- Set slvreq[c]=1, clear the counter, go to SLV.

R>NSLV: armack=1, armerr=1, armrdata=0 the next cycle.

SLV state:
- slvreq[c] is held.
- slvack[c]=1 → slvreq[c]=0, armack=1, armrdata=slvrdata[c], armerr=slverr[c], return to IDLE.
- Otherwise the counter increments. On the edge where it equals TIMEOUT-1 and slvack[c]=0 → slvreq[c]=0, armack=1, armerr=1, armrdata=0xDEADBEEF, return to IDLE.
- slvack and the timeout limit in the same cycle: ack wins.
- slvack on an unselected channel, or a late slvack after a timeout: ignored.

Latency:
- Local or decode error: 1 cycle after the start.
- Slave access: 1 cycle after slvack is sampled.
- Only one transaction is ever outstanding.

Reset mid-SLV: slvreq drops immediately and no armack is produced.

Decomposition:
- Package dport_pkg holds:
  - state encoding IDLE/SLV,
  - STS_BASE=0x100,
  - DEADBEEF timeout pattern,
  - region field position 23:20.
- Sub-module regs_strb_reg: one 32-bit byte-strobed register with async reset value, instantiated NCTL times by generate.

Test Plan:
- Write 0x12345678 to 0x000004 with strobe 4'b0101 after reset, CTL_RST=0 → ctl[1]=0x00340078; armack 1 cycle later; armerr=0.
- Read 0x000100 with sts[0]=0xCAFEF00D → armrdata=0xCAFEF00D, armerr=0; read 0x000200 → armack with armerr=1, armrdata=0.
- Read 0x200010 (channel 1), slave acks 3 cycles later with rdata 0xA5, err=0 → slvaddr=0x00010, slvreq[1] high 3 cycles, armrdata=0xA5 with armack the next cycle.
- Access to channel 0 with no slvack, TIMEOUT=16 → slvreq[0] drops on the 16th SLV edge; armack=1, armerr=1, armrdata=0xDEADBEEF; a slvack on the following cycle is ignored.
- Access to 0xF00000 with NSLV=2 → immediate error ack; assert rst during a pending slave access → slvreq=0 at once, ctl=CTL_RST, no armack.
